uart_tx_fifo: RTL

// - Byte-buffered front end for UART_sender: stores bytes from a producer in a

---
 rtl/uart_tx_fifo.sv | 121 ++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO that feeds a UART sender through its start/data/busy handshake.
// Optional statistics counters are enabled with `define UART_TX_FIFO_STATS_EN.
module uart_tx_fifo #(
   parameter int unsigned DEPTH   = 16,
   parameter int unsigned ADDR_W  = 4,
   parameter int unsigned BUSY_TO = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [7:0]        wr_data,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   level,
   output logic              overflow,
`ifdef UART_TX_FIFO_STATS_EN
   output logic [15:0]       sent_cnt,
   output logic [15:0]       drop_cnt,
`endif
   input  logic              tx_busy,
   output logic              tx_start,
   output logic [7:0]        tx_data
);

   localparam int unsigned PTR_W = ADDR_W + 1;
   localparam int unsigned TO_W  = $clog2(BUSY_TO + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LAUNCH,
      ST_WAIT_BUSY,
      ST_WAIT_DONE
   } state_t;

   state_t            state;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [TO_W-1:0]   to_cnt;
   logic [7:0]        mem [DEPTH];
   logic              pop_c;
   logic              wr_acc_c;
   logic              wr_drop_c;

   // Occupancy flags come straight from the pointer registers.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                  (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
   assign level = wr_ptr - rd_ptr;

   // The pop happens on the edge that enters LAUNCH, so a full FIFO can take a write then.
   assign pop_c     = (state == ST_IDLE) && !empty && !tx_busy;
   assign wr_acc_c  = wr_en && (!full || pop_c);
   assign wr_drop_c = wr_en && full && !pop_c;

   always_ff @(posedge clk) begin
      if (wr_acc_c) mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr_acc_c)  wr_ptr   <= wr_ptr + PTR_W'(1);
         if (pop_c)     rd_ptr   <= rd_ptr + PTR_W'(1);
         if (wr_drop_c) overflow <= 1'b1;
      end
   end

   // Launch sequencer; tx_start and tx_data are registered alongside the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         tx_start <= 1'b0;
         tx_data  <= 8'h00;
         to_cnt   <= '0;
      end else begin
         tx_start <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (pop_c) begin
                  state    <= ST_LAUNCH;
                  tx_start <= 1'b1;
                  tx_data  <= mem[rd_ptr[ADDR_W-1:0]];
               end
            end
            ST_LAUNCH: begin
               state  <= ST_WAIT_BUSY;
               to_cnt <= '0;
            end
            ST_WAIT_BUSY: begin
               if (tx_busy)
                  state <= ST_WAIT_DONE;
               else if (to_cnt == TO_W'(BUSY_TO - 1))
                  state <= ST_IDLE;
               else
                  to_cnt <= to_cnt + TO_W'(1);
            end
            ST_WAIT_DONE: begin
               if (!tx_busy) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef UART_TX_FIFO_STATS_EN
   // Launch counter wraps; drop counter saturates.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sent_cnt <= 16'h0000;
         drop_cnt <= 16'h0000;
      end else begin
         if (pop_c) sent_cnt <= sent_cnt + 16'h0001;
         if (wr_drop_c && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'h0001;
      end
   end
`endif

endmodule
